// File: rtl/cla_seq32.sv
// Sequential adder: one 8-bit slice reused over NBYTES cycles, LSB byte first,
// with a valid/ready request side and a held result until the consumer takes it.
module cla_seq32 #(
   parameter int unsigned NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  cout,
   output logic                  busy
);

   localparam int unsigned W  = 8 * NBYTES;
   localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t          state;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic            carry_reg;
   logic [IW-1:0]   idx;

   logic [IW+2:0]   byte_off;
   logic [7:0]      byte_a;
   logic [7:0]      byte_b;
   logic [8:0]      slice;

   // Shared byte slice: selected operand bytes plus the running carry
   assign byte_off = {idx, 3'b000};
   assign byte_a   = op_a[byte_off +: 8];
   assign byte_b   = op_b[byte_off +: 8];
   assign slice    = {1'b0, byte_a} + {1'b0, byte_b} + 9'(carry_reg);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         carry_reg <= 1'b0;
         idx       <= '0;
         sum       <= '0;
         cout      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a      <= a;
                  op_b      <= b;
                  carry_reg <= cin;
                  idx       <= '0;
                  state     <= ADD;
               end
            end
            ADD: begin
               sum[byte_off +: 8] <= slice[7:0];
               carry_reg          <= slice[8];
               // Final byte: capture carry-out and hold idx so it never wraps
               if (idx == LAST_IDX) begin
                  cout  <= slice[8];
                  state <= DONE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_seq32.sv
// Directed-vector bench for cla_seq32 (NBYTES=4): reset, carry chains,
// latency, backpressure and reset during an operation.
module tb_cla_seq32;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   cla_seq32 #(.NBYTES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operation and return at the negedge after the acceptance edge
   task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
      @(negedge clk);
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom; b = $urandom; cin = 1'b0;
   endtask

   // Count negedge samples from the acceptance edge until out_valid (bounded)
   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h1; cin = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 00000000", sum); end
      n_checks++;
      if ({cout, in_ready, out_valid, busy} !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_flags: cout/in_ready/out_valid/busy got %b want 0100",
                  {cout, in_ready, out_valid, busy});
      end
   endtask

   task automatic test_carry_prop();
      int lat;
      start_op(32'hFFFFFFFF, 32'h00000000, 1'b1);
      in_valid = 1'b1;
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL carry_add_flags: in_ready=%b busy=%b want 0 1", in_ready, busy);
      end
      wait_done(lat);
      in_valid = 1'b0;
      n_checks++;
      if (lat !== 5) begin n_fail++; $display("FAIL carry_latency: got %0d want 5", lat); end
      n_checks++;
      if ({cout, sum} !== 33'h1_0000_0000) begin
         n_fail++; $display("FAIL carry_result: got %b_%h want 1_00000000", cout, sum);
      end
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL carry_done_flags: busy=%b in_ready=%b want 1 0", busy, in_ready);
      end
      drain();
   endtask

   task automatic test_all_ones();
      int lat;
      start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      wait_done(lat);
      n_checks++;
      if ({cout, sum} !== 33'h1_FFFF_FFFE) begin
         n_fail++; $display("FAIL all_ones_cin0: got %b_%h want 1_fffffffe", cout, sum);
      end
      drain();
      start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      wait_done(lat);
      n_checks++;
      if ({cout, sum} !== 33'h1_FFFF_FFFF) begin
         n_fail++; $display("FAIL all_ones_cin1: got %b_%h want 1_ffffffff", cout, sum);
      end
      drain();
   endtask

   task automatic test_byte_boundary();
      int lat;
      start_op(32'h000000FF, 32'h00000001, 1'b0);
      wait_done(lat);
      n_checks++;
      if ({cout, sum} !== 33'h0_0000_0100) begin
         n_fail++; $display("FAIL byte_carry: got %b_%h want 0_00000100", cout, sum);
      end
      drain();
      start_op(32'h00000003, 32'h00000001, 1'b1);
      wait_done(lat);
      n_checks++;
      if ({cout, sum} !== 33'h0_0000_0005) begin
         n_fail++; $display("FAIL cin_add: got %b_%h want 0_00000005", cout, sum);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      start_op(32'h89ABCDEF, 32'h76543210, 1'b0);
      wait_done(lat);
      bad = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = ~a; b = b ^ 32'h5A5A5A5A; cin = ~cin;
         @(negedge clk);
         if ({cout, sum} !== 33'h0_FFFF_FFFF || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL bp_hold: %0d bad cycles, last %b_%h in_ready=%b want 0 bad", bad, cout, sum, in_ready);
      end
      out_ready = 1'b1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0", in_ready); end
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      @(negedge clk);
      n_checks++;
      if ({cout, sum} !== 33'h0_FFFF_FFFF) begin
         n_fail++; $display("FAIL idle_retain: got %b_%h want 0_ffffffff", cout, sum);
      end
   endtask

   task automatic test_reset_mid_op();
      int lat;
      int seen;
      start_op(32'hA5A5A5A5, 32'h01010101, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || sum !== 32'h0) begin
         n_fail++; $display("FAIL midrst_state: in_ready=%b busy=%b sum=%h want 1 0 00000000", in_ready, busy, sum);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_valid: out_valid seen %0d times want 0", seen); end
      start_op(32'h12345678, 32'h11111111, 1'b0);
      wait_done(lat);
      n_checks++;
      if (lat !== 5 || {cout, sum} !== 33'h0_2345_6789) begin
         n_fail++; $display("FAIL midrst_next_op: lat=%0d got %b_%h want 5 0_23456789", lat, cout, sum);
      end
      drain();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      test_reset();
      test_carry_prop();
      test_all_ones();
      test_byte_boundary();
      test_backpressure();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
